// File: rtl/decoder_sel_sequencer.sv
// Timed 3-bit select-code sweeper feeding a 3-to-8 decoder (x = MSB, z = LSB).
// Define SCAN_BOUNCE_EN to append a reverse pass (SWEEP_B) after the first pass.
module decoder_sel_sequencer #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic up_down,
  input  logic hold,
  output logic x,
  output logic y,
  output logic z,
  output logic busy,
  output logic step,
  output logic done
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSweepA,
    StSweepB
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  logic            dir_q, dir_d;
  logic            busy_q, busy_d;
  logic            step_q, step_d;
  logic            done_q, done_d;
  logic            last_code;

  // End of the current pass depends on the latched (possibly inverted) direction.
  assign last_code = dir_q ? (code_q == 3'd7) : (code_q == 3'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSweepA;
          code_d  = up_down ? 3'd0 : 3'd7;
          cnt_d   = '0;
          dir_d   = up_down;
          busy_d  = 1'b1;
        end
      end
      StSweepA, StSweepB: begin
        if (!hold) begin
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (!last_code) begin
              code_d = dir_q ? (code_q + 3'd1) : (code_q - 3'd1);
              step_d = 1'b1;
`ifdef SCAN_BOUNCE_EN
            end else if (state_q == StSweepA) begin
              // End value is held for a second dwell on the way back.
              state_d = StSweepB;
              dir_d   = ~dir_q;
              step_d  = 1'b1;
`endif
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= 3'd0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign x    = code_q[2];
  assign y    = code_q[1];
  assign z    = code_q[0];
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// Directed bench for decoder_sel_sequencer with TICK_DIV=4; follows SCAN_BOUNCE_EN if defined.
module tb_decoder_sel_sequencer;

  localparam int Tick = 4;
`ifdef SCAN_BOUNCE_EN
  localparam int Total = 16 * Tick;
`else
  localparam int Total = 8 * Tick;
`endif

  logic clk = 1'b0;
  logic reset, start, up_down, hold;
  logic x, y, z, busy, step, done;
  logic [2:0] code;

  int n_tests = 0;
  int n_fail  = 0;

  assign code = {x, y, z};

  always #5 clk = ~clk;

  decoder_sel_sequencer #(
    .TICK_DIV(Tick)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .up_down(up_down),
    .hold   (hold),
    .x      (x),
    .y      (y),
    .z      (z),
    .busy   (busy),
    .step   (step),
    .done   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Code shown during dwell d of a sweep (d counts dwells from 0).
  function automatic logic [2:0] exp_code(input logic up, input int d);
    int v;
    v = (d < 8) ? d : 15 - d;
    return up ? 3'(v) : 3'(7 - v);
  endfunction

  // Starts a sweep and checks every cycle up to the done sample. Hold is high for the
  // edges hold_at+1 .. hold_at+hold_len; a stray start is offered before edge poke_at.
  task automatic run_sweep(input logic up, input int hold_at, input int hold_len,
                           input int poke_at, input string tag);
    int   u, steps, done_k, busy_n;
    logic held;
    start   = 1'b1;
    up_down = up;
    tick();
    start = 1'b0;
    check_eq({tag, " busy@start"}, 32'(busy), 32'd1);
    check_eq({tag, " code@start"}, 32'(code), 32'(exp_code(up, 0)));
    u = 0; steps = 0; done_k = -1; busy_n = 1;
    for (int k = 1; k <= Total + hold_len; k++) begin
      held    = (k > hold_at) && (k <= hold_at + hold_len);
      hold    = held;
      start   = (k == poke_at);
      up_down = (k == poke_at) ? ~up : up;
      tick();
      if (!held) u++;
      check_eq($sformatf("%s code k=%0d", tag, k), 32'(code),
               32'(exp_code(up, ((u >= Total) ? Total - 1 : u) / Tick)));
      check_eq($sformatf("%s step k=%0d", tag, k), 32'(step),
               32'(!held && (u % Tick == 0) && (u < Total)));
      check_eq($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(!held && (u == Total)));
      check_eq($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(u < Total));
      if (step) steps++;
      if (done && done_k < 0) done_k = k;
      if (busy) busy_n++;
    end
    hold  = 1'b0;
    start = 1'b0;
    check_eq({tag, " step count"}, 32'(steps), 32'(Total / Tick - 1));
    check_eq({tag, " done cycle"}, 32'(done_k), 32'(Total + hold_len));
    check_eq({tag, " busy cycles"}, 32'(busy_n), 32'(Total + hold_len));
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; up_down = 1'b1; hold = 1'b0;
    tick();
    tick();
    check_eq("reset code", 32'(code), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset step", 32'(step), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    run_sweep(1'b1, 1000, 0, -1, "up");
    tick();
    tick();
    check_eq("up idle code", 32'(code), 32'(exp_code(1'b1, Total / Tick - 1)));
    check_eq("up idle busy", 32'(busy), 32'd0);
    check_eq("up idle done", 32'(done), 32'd0);

    // Second sweep starts from the done cycle itself.
    run_sweep(1'b0, 1000, 0, -1, "down");
    run_sweep(1'b0, 1000, 0, -1, "down2");
    tick();

    // Hold during the code-3 dwell stretches it to 14 cycles.
    run_sweep(1'b1, 13, 10, -1, "hold");
    tick();

    // Abort mid-sweep; a start offered while busy must be ignored.
    start = 1'b1; up_down = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      start   = (k == 6);
      up_down = (k == 6) ? 1'b0 : 1'b1;
      tick();
      if (k == 8) check_eq("poke ignored code", 32'(code), 32'd2);
    end
    start = 1'b0; up_down = 1'b1;
    check_eq("abort pre code", 32'(code), 32'd5);
    reset = 1'b1;
    #1;
    check_eq("abort code", 32'(code), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) dones++;
    end
    check_eq("abort no done", 32'(dones), 32'd0);
    check_eq("abort idle code", 32'(code), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
